// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: writes a pattern across an address range,
// reads it back one word at a time and reports mismatches.
module sdram_pattern_tester #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk100,
    input  logic                rst_p,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                stop_on_fail,
    input  logic [ADDR_W-1:0]   addr_lo,
    input  logic [ADDR_W-1:0]   addr_hi,
    input  logic                cmd_ready,
    output logic                cmd_enable,
    output logic                cmd_wr,
    output logic [ADDR_W-1:0]   cmd_address,
    output logic [DATA_W-1:0]   cmd_data_in,
    output logic [DATA_W/8-1:0] cmd_byte_enable,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic                bad_cfg,
    output logic                timeout,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_data
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE, FAIL
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
    logic [1:0] mode_q, mode_d;
    logic sof_q, sof_d;
    logic cmd_en_q, cmd_en_d, cmd_wr_q, cmd_wr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic timeout_q, timeout_d, bad_cfg_q, bad_cfg_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic mism;

    function automatic logic [DATA_W-1:0] pat(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] a
    );
        logic [ADDR_W-1:0] o;
        logic [DATA_W-1:0] r;
        o = a - lo;
        case (m)
            2'd0:    r = DATA_W'(o);
            2'd1:    r = DATA_W'(a);
            2'd2:    r = DATA_W'(1) << (o % ADDR_W'(DATA_W));
            default: r = ~DATA_W'(a);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        mode_d      = mode_q;
        sof_d       = sof_q;
        cmd_en_d    = cmd_en_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_data_d  = cmd_data_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        timeout_d   = timeout_q;
        bad_cfg_d   = bad_cfg_q;
        tcnt_d      = tcnt_q;
        mism        = rd_data != pat(mode_q, lo_q, addr_q);
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    if (addr_lo > addr_hi) begin
                        state_d   = FAIL;
                        bad_cfg_d = 1'b1;
                        timeout_d = 1'b0;
                    end else begin
                        lo_d       = addr_lo;
                        hi_d       = addr_hi;
                        mode_d     = mode;
                        sof_d      = stop_on_fail;
                        err_d      = '0;
                        timeout_d  = 1'b0;
                        bad_cfg_d  = 1'b0;
                        addr_d     = addr_lo;
                        cmd_en_d   = 1'b1;
                        cmd_wr_d   = 1'b1;
                        cmd_data_d = pat(mode, addr_lo, addr_lo);
                        state_d    = WR_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                // enable drops for one cycle after each acceptance
                if (cmd_en_q) begin
                    if (cmd_ready) begin
                        cmd_en_d = 1'b0;
                        if (addr_q == hi_q) begin
                            addr_d  = lo_q;
                            state_d = RD_ISSUE;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end else begin
                    cmd_en_d   = 1'b1;
                    cmd_data_d = pat(mode_q, lo_q, addr_q);
                end
            end
            RD_ISSUE: begin
                if (!cmd_en_q) begin
                    cmd_en_d = 1'b1;
                    cmd_wr_d = 1'b0;
                end else if (cmd_ready) begin
                    cmd_en_d = 1'b0;
                    tcnt_d   = '0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_valid) begin
                    tcnt_d = '0;
                    if (mism) begin
                        if (err_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_data_d = rd_data;
                        end
                        err_d = (&err_q) ? err_q : err_q + 1'b1;
                    end
                    if (mism && sof_q) begin
                        state_d = FAIL;
                    end else if (addr_q == hi_q) begin
                        state_d = (!mism && err_q == '0) ? DONE : FAIL;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = FAIL;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            mode_q      <= '0;
            sof_q       <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_data_q  <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            timeout_q   <= 1'b0;
            bad_cfg_q   <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            mode_q      <= mode_d;
            sof_q       <= sof_d;
            cmd_en_q    <= cmd_en_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_data_q  <= cmd_data_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            timeout_q   <= timeout_d;
            bad_cfg_q   <= bad_cfg_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign cmd_enable      = cmd_en_q;
    assign cmd_wr          = cmd_wr_q;
    assign cmd_address     = addr_q;
    assign cmd_data_in     = cmd_data_q;
    assign cmd_byte_enable = '1;
    assign busy      = state_q inside {WR_ISSUE, RD_ISSUE, RD_WAIT};
    assign done      = state_q == DONE;
    assign fail      = state_q == FAIL;
    assign bad_cfg   = bad_cfg_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench for sdram_pattern_tester with a small SDRAM model.
// Expected commands are queued per test; a monitor pops them on acceptance.
module tb_sdram_pattern_tester;
    localparam int AW = 23;
    localparam int DW = 32;

    logic clk100 = 0, rst_p = 1, start = 0, stop_on_fail = 0;
    logic cmd_ready = 0, rd_valid = 0;
    logic [1:0] mode = 0;
    logic [AW-1:0] addr_lo = 0, addr_hi = 0;
    logic [DW-1:0] rd_data = 0;
    logic cmd_enable, cmd_wr, busy, done, fail, bad_cfg, timeout;
    logic [AW-1:0] cmd_address, fail_addr;
    logic [DW-1:0] cmd_data_in, fail_data;
    logic [DW/8-1:0] cmd_byte_enable;
    logic [15:0] err_count;

    sdram_pattern_tester dut (
        .clk100(clk100), .rst_p(rst_p), .start(start), .mode(mode),
        .stop_on_fail(stop_on_fail), .addr_lo(addr_lo),
        .addr_hi(addr_hi), .cmd_ready(cmd_ready),
        .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
        .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
        .cmd_byte_enable(cmd_byte_enable), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .fail(fail),
        .bad_cfg(bad_cfg), .timeout(timeout), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t exp_q[$];
    int total = 0, bad = 0, cyc = 0, rd_cyc = 0;
    logic [DW-1:0] mem [int unsigned];
    bit corrupt [int unsigned];
    int unsigned rdq[$];
    bit drop = 0, stall = 0, inject = 0, pend = 0, rd_seen = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_pat(int m, longint lo, longint a);
        longint o;
        o = a - lo;
        case (m)
            0: return o[31:0];
            1: return a[31:0];
            2: return 32'h1 << (o % 32);
            default: return ~a[31:0];
        endcase
    endfunction

    task automatic push(bit wr, longint a, logic [31:0] d);
        cmd_t c;
        c.wr = wr;
        c.a  = a[AW-1:0];
        c.d  = d;
        exp_q.push_back(c);
    endtask

    initial forever begin
        @(posedge clk100);
        cyc++;
    end

    // monitor: every accepted command is checked against the scoreboard
    initial forever begin
        cmd_t e;
        @(negedge clk100);
        if (!rst_p && cmd_enable && cmd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd: got wr=%0d addr=%0h want none",
                         cmd_wr, cmd_address);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_wr", cmd_wr, e.wr);
                chk("cmd_addr", cmd_address, e.a);
                if (e.wr) chk("cmd_data", cmd_data_in, e.d);
                chk("byte_en", cmd_byte_enable, 4'hF);
            end
            if (cmd_wr) mem[cmd_address] = cmd_data_in;
            else begin
                rdq.push_back(cmd_address);
                rd_seen = 1;
                rd_cyc  = cyc;
            end
        end
    end

    // SDRAM model: random ready stalls, random read latency, corruption
    initial begin
        int unsigned pa;
        int dly;
        pa = 0;
        dly = 0;
        forever begin
            @(posedge clk100);
            #1;
            rd_valid  = 0;
            cmd_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (inject) begin
                rd_valid = 1;
                rd_data  = $urandom;
                inject   = 0;
            end else if (drop) begin
                rdq.delete();
                pend = 0;
            end else if (pend) begin
                if (dly == 0) begin
                    rd_valid = 1;
                    rd_data  = corrupt.exists(pa) ? 32'hDEADBEEF : mem[pa];
                    pend     = 0;
                end else dly--;
            end else if (rdq.size() > 0) begin
                pa   = rdq.pop_front();
                dly  = $urandom_range(0, 3);
                pend = 1;
            end
        end
    end

    task automatic pulse(int m, longint lo, longint hi, bit sof);
        @(posedge clk100);
        #1;
        mode = m[1:0];
        addr_lo = lo[AW-1:0];
        addr_hi = hi[AW-1:0];
        stop_on_fail = sof;
        start = 1;
        @(posedge clk100);
        #1;
        start = 0;
        mode = 2'($urandom);
        addr_lo = AW'($urandom);
        addr_hi = AW'($urandom);
        stop_on_fail = 1'($urandom);
    endtask

    task automatic wait_end(string tag, int limit);
        int n;
        n = 0;
        while (!(done || fail) && n < limit) begin
            @(negedge clk100);
            n++;
        end
        if (!(done || fail)) begin
            total++;
            bad++;
            $display("FAIL %s.wait: got no done/fail want one within %0d",
                     tag, limit);
        end
    endtask

    task automatic run(int m, longint lo, longint hi, bit sof, string tag);
        int errs;
        longint first;
        errs = 0;
        first = 0;
        for (longint a = lo; a <= hi; a++) push(1, a, ref_pat(m, lo, a));
        for (longint a = lo; a <= hi; a++) begin
            push(0, a, 0);
            if (corrupt.exists(int'(a))) begin
                if (errs == 0) first = a;
                errs++;
                if (sof) break;
            end
        end
        pulse(m, lo, hi, sof);
        wait_end(tag, 20000);
        @(negedge clk100);
        chk({tag, ".done"}, done, errs == 0);
        chk({tag, ".fail"}, fail, errs != 0);
        chk({tag, ".err_count"}, err_count, errs);
        if (errs != 0) begin
            chk({tag, ".fail_addr"}, fail_addr, first);
            chk({tag, ".fail_data"}, fail_data, 32'hDEADBEEF);
        end
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".bad_cfg"}, bad_cfg, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".left_cmds"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n, el;
        longint lo, hi;
        rst_p = 1;
        repeat (3) @(negedge clk100);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.fail", fail, 0);
        chk("rst.flags", {bad_cfg, timeout}, 0);
        chk("rst.err_count", err_count, 0);
        chk("rst.fail_addr", fail_addr, 0);
        chk("rst.fail_data", fail_data, 0);
        chk("rst.cmd", {cmd_enable, cmd_wr}, 0);
        chk("rst.cmd_addr", cmd_address, 0);
        chk("rst.cmd_data", cmd_data_in, 0);
        @(posedge clk100);
        #1;
        rst_p = 0;

        stall = 1;
        run(0, 0, 15, 0, "inc");
        corrupt[5] = 1;
        run(1, 0, 15, 1, "sof");
        corrupt[9] = 1;
        run(1, 0, 15, 0, "cnt");
        corrupt.delete();
        run(2, 30, 35, 0, "walk");

        pulse(0, 7, 3, 0);
        repeat (4) @(negedge clk100);
        chk("badcfg.bad_cfg", bad_cfg, 1);
        chk("badcfg.fail", fail, 1);
        chk("badcfg.busy", {busy, done, cmd_enable}, 0);

        run(3, 'h7FFFFE, 'h7FFFFF, 0, "top");

        for (int i = 0; i < 5; i++) begin
            lo = $urandom_range(0, (1 << AW) - 40);
            hi = lo + $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1)
                corrupt[int'(lo + $urandom_range(0, int'(hi - lo)))] = 1;
            run($urandom_range(0, 3), lo, hi, 1'($urandom), $sformatf("rnd%0d", i));
            corrupt.delete();
        end

        drop = 1;
        push(1, 0, 0);
        push(1, 1, 1);
        push(0, 0, 0);
        pulse(0, 0, 1, 0);
        wait_end("tmo", 3000);
        @(negedge clk100);
        el = cyc - rd_cyc;
        chk("tmo.timeout", timeout, 1);
        chk("tmo.fail", {fail, done}, 2'b10);
        chk("tmo.cycles_ok", (el >= 1020 && el <= 1030), 1);
        chk("tmo.left_cmds", exp_q.size(), 0);
        exp_q.delete();

        for (longint a = 0; a <= 3; a++) push(1, a, ref_pat(0, 0, a));
        push(0, 0, 0);
        rd_seen = 0;
        pulse(0, 0, 3, 0);
        n = 0;
        while (!rd_seen && n < 500) begin
            @(negedge clk100);
            n++;
        end
        chk("rstmid.read_seen", rd_seen, 1);
        repeat (5) @(posedge clk100);
        #1;
        rst_p = 1;
        repeat (2) @(posedge clk100);
        #1;
        rst_p = 0;
        exp_q.delete();
        rdq.delete();
        pend = 0;
        drop = 0;
        inject = 1;
        repeat (6) @(negedge clk100);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.status", {done, fail, timeout, bad_cfg}, 0);
        chk("rstmid.err_count", err_count, 0);
        chk("rstmid.cmd_enable", cmd_enable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
